// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  localparam int DEF_N_MASTERS = 4;
  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } arb_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_arb_if.sv
// Bundled master-side and slave-side Wishbone signals of the N:1 arbiter.
interface wb_rr_arb_if
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW
);
  localparam int SEL_W = DW / 8;

  logic [N_MASTERS-1:0]       m_cyc_i;
  logic [N_MASTERS-1:0]       m_stb_i;
  logic [N_MASTERS-1:0]       m_we_i;
  logic [N_MASTERS*AW-1:0]    m_adr_i;
  logic [N_MASTERS*DW-1:0]    m_dat_i;
  logic [N_MASTERS*SEL_W-1:0] m_sel_i;
  logic [DW-1:0]              m_dat_o;
  logic [N_MASTERS-1:0]       m_ack_o;
  logic [N_MASTERS-1:0]       m_err_o;

  logic                       s_cyc_o;
  logic                       s_stb_o;
  logic                       s_we_o;
  logic [AW-1:0]              s_adr_o;
  logic [DW-1:0]              s_dat_o;
  logic [SEL_W-1:0]           s_sel_o;
  logic [DW-1:0]              s_dat_i;
  logic                       s_ack_i;
  logic                       s_err_i;

  logic [N_MASTERS-1:0]       grant_o;

  // Arbiter view: requests and slave responses in, routed signals out.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output grant_o
  );

  // Environment view: the masters and the slave surrounding the arbiter.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  grant_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker: searches upward from i_last+1 (mod N).
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int IW        = clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IW-1:0]        i_last,
  output logic [N_MASTERS-1:0] o_onehot,
  output logic [IW-1:0]        o_idx,
  output logic                 o_valid
);

  logic          w_found;
  logic [IW-1:0] w_k;

  // NOTE: every variable written here gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_k      = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      w_k = IW'((int'(i_last) + i) % N_MASTERS);
      if (!w_found && i_req[w_k]) begin
        w_found       = 1'b1;
        o_idx         = w_k;
        o_onehot[w_k] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/wb_rr_arb.sv
// N-master to 1-slave Wishbone arbiter with registered round-robin grant held per CYC.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arb
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = DEF_N_MASTERS,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  wb_rr_arb_if.slave  bus
);

  localparam int IW    = clog2(N_MASTERS);
  localparam int SEL_W = DW / 8;

  arb_state_e           r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_last;

  logic [N_MASTERS-1:0] w_pick_oh;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_owner_cyc;
  logic                 w_timeout;

  wb_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IW        (IW)
  ) u_pick (
    .i_req    (bus.m_cyc_i),
    .i_last   (r_last),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_owner_cyc = bus.m_cyc_i[r_gidx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(N_MASTERS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_oh;
            r_gidx  <= w_pick_idx;
            r_state <= BUS;
          end
        end
        BUS: begin
          if (!w_owner_cyc || w_timeout) begin
            r_grant <= '0;
            r_last  <= r_gidx;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wd_cnt;

  assign w_timeout = (r_state == BUS) && (r_wd_cnt == CW'(TIMEOUT_CYCLES));

  // Counts only stalled strobe cycles; any response or loss of ownership restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state != BUS || bus.s_ack_i || bus.s_err_i || w_timeout) begin
      r_wd_cnt <= '0;
    end else if (bus.s_stb_o) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (r_state == BUS) begin
      bus.s_cyc_o         = bus.m_cyc_i[r_gidx];
      bus.s_stb_o         = bus.m_stb_i[r_gidx];
      bus.s_we_o          = bus.m_we_i[r_gidx];
      bus.s_adr_o         = bus.m_adr_i[int'(r_gidx) * AW +: AW];
      bus.s_dat_o         = bus.m_dat_i[int'(r_gidx) * DW +: DW];
      bus.s_sel_o         = bus.m_sel_i[int'(r_gidx) * SEL_W +: SEL_W];
      bus.m_ack_o[r_gidx] = bus.s_ack_i;
      bus.m_err_o[r_gidx] = bus.s_err_i;
      if (w_timeout) begin
        bus.s_cyc_o         = 1'b0;
        bus.s_stb_o         = 1'b0;
        bus.m_err_o[r_gidx] = 1'b1;
      end
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arb.sv
// Directed bench for wb_rr_arb with an ack/grant scoreboard; honours WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  logic [N-1:0] sb_q[$];
  logic [N-1:0] g_q[$];

  logic [N-1:0] drop_p;
  logic [N-1:0] raise_p;
  logic [N-1:0] prev_g;
  logic [N-1:0] cur_exp;
  logic [N-1:0] exp_err;
  int           idle_cnt;
  int           n_grants;
  bit           done;

  wb_rr_arb_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arb #(
    .N_MASTERS      (N),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pop_ack(input string tag);
    logic [N-1:0] e;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    check(tag, 64'(bus.m_ack_o), 64'(e));
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '1;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst = 1'b1;
    #2;
    check("rst_grant",  64'(bus.grant_o), 0);
    check("rst_s_cyc",  64'(bus.s_cyc_o), 0);
    check("rst_s_stb",  64'(bus.s_stb_o), 0);
    check("rst_s_we",   64'(bus.s_we_o),  0);
    check("rst_m_ack",  64'(bus.m_ack_o), 0);
    check("rst_m_err",  64'(bus.m_err_o), 0);
    step();
    check("rst_hold_grant", 64'(bus.grant_o), 0);
    rst = 1'b0;

    // Single request from master 2, slave acks on its second cycle.
    step();
    bus.m_cyc_i[2] = 1'b1;
    bus.m_stb_i[2] = 1'b1;
    bus.m_we_i[2]  = 1'b1;
    bus.m_adr_i[2*AW +: AW] = 32'h0000_0100;
    bus.m_dat_i[2*DW +: DW] = 32'h1234_5678;
    settle();
    check("single_pre_grant", 64'(bus.grant_o), 0);
    check("single_pre_cyc",   64'(bus.s_cyc_o), 0);
    step();
    check("single_grant", 64'(bus.grant_o), 64'(4'b0100));
    check("single_s_cyc", 64'(bus.s_cyc_o), 1);
    check("single_s_we",  64'(bus.s_we_o),  1);
    check("single_s_adr", 64'(bus.s_adr_o), 64'h100);
    check("single_s_dat", 64'(bus.s_dat_o), 64'h1234_5678);
    check("single_noack", 64'(bus.m_ack_o), 0);
    step();
    bus.s_ack_i = 1'b1;
    sb_q.push_back(4'b0100);
    settle();
    pop_ack("single_ack");
    step();
    bus.s_ack_i    = 1'b0;
    bus.m_cyc_i[2] = 1'b0;
    bus.m_stb_i[2] = 1'b0;
    bus.m_we_i[2]  = 1'b0;
    settle();
    check("single_ack_drop", 64'(bus.m_ack_o), 0);
    check("single_cyc_drop", 64'(bus.s_cyc_o), 0);
    step();
    check("single_release", 64'(bus.grant_o), 0);

    // All four masters contend from reset; each drops CYC for one cycle after its ack.
    clear_inputs();
    do_reset();
    g_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev_g   = '0;
    cur_exp  = '0;
    idle_cnt = 0;
    n_grants = 0;
    drop_p   = '0;
    raise_p  = '0;
    done     = 1'b0;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    settle();
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (drop_p[k]) begin
          bus.m_cyc_i[k] = 1'b0;
          bus.m_stb_i[k] = 1'b0;
          raise_p[k]     = 1'b1;
        end else if (raise_p[k]) begin
          bus.m_cyc_i[k] = 1'b1;
          bus.m_stb_i[k] = 1'b1;
          raise_p[k]     = 1'b0;
        end
      end
      drop_p = '0;
      bus.s_ack_i = 1'b0;
      settle();
      bus.s_ack_i = bus.s_stb_o;
      settle();
      if (bus.grant_o == '0) begin
        idle_cnt++;
      end else if (bus.grant_o != prev_g) begin
        cur_exp = (g_q.size() != 0) ? g_q.pop_front() : 'x;
        check("rr_grant", 64'(bus.grant_o), 64'(cur_exp));
        if (n_grants > 0) check("rr_dead_cycle", 64'(idle_cnt), 1);
        n_grants++;
        idle_cnt = 0;
      end
      prev_g = bus.grant_o;
      if (bus.m_ack_o != '0) begin
        check("rr_ack_route", 64'(bus.m_ack_o), 64'(cur_exp));
        drop_p = bus.m_ack_o;
        if (n_grants == 5) done = 1'b1;
      end
    end
    check("rr_all_grants", 64'(n_grants), 5);
    check("rr_queue_empty", 64'(g_q.size()), 0);
    clear_inputs();
    step();
    step();
    check("rr_idle_after", 64'(bus.grant_o), 0);

    // Master 1 bursts four beats in one CYC while master 0 waits.
    do_reset();
    bus.m_cyc_i[1] = 1'b1;
    bus.m_stb_i[1] = 1'b1;
    settle();
    step();
    check("burst_grant", 64'(bus.grant_o), 64'(4'b0010));
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.s_ack_i = 1'b1;
      sb_q.push_back(4'b0010);
      settle();
      pop_ack("burst_ack");
      check("burst_grant_hold", 64'(bus.grant_o), 64'(4'b0010));
      step();
    end
    bus.s_ack_i    = 1'b0;
    bus.m_cyc_i[1] = 1'b0;
    bus.m_stb_i[1] = 1'b0;
    settle();
    check("burst_release_cycle", 64'(bus.grant_o), 64'(4'b0010));
    step();
    check("burst_dead_cycle", 64'(bus.grant_o), 0);
    step();
    check("burst_next_owner", 64'(bus.grant_o), 64'(4'b0001));
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    step();
    step();

    // Read by master 3, then a beat with ack and err together.
    bus.m_cyc_i[3] = 1'b1;
    bus.m_stb_i[3] = 1'b1;
    bus.m_we_i[3]  = 1'b0;
    bus.m_adr_i[3*AW +: AW] = 32'h0000_0300;
    settle();
    step();
    check("read_grant", 64'(bus.grant_o), 64'(4'b1000));
    bus.s_dat_i = 32'hDEAD_BEEF;
    bus.s_ack_i = 1'b1;
    sb_q.push_back(4'b1000);
    settle();
    check("read_data",  64'(bus.m_dat_o), 64'hDEAD_BEEF);
    pop_ack("read_ack");
    check("read_s_we",  64'(bus.s_we_o),  0);
    check("read_s_adr", 64'(bus.s_adr_o), 64'h300);
    step();
    bus.s_err_i = 1'b1;
    sb_q.push_back(4'b1000);
    settle();
    pop_ack("ackerr_ack");
    check("ackerr_err", 64'(bus.m_err_o), 64'(4'b1000));
    step();
    clear_inputs();
    step();
    step();

    // Asynchronous reset while master 1 owns the bus.
    bus.m_cyc_i[1] = 1'b1;
    bus.m_stb_i[1] = 1'b1;
    settle();
    step();
    check("arst_pre_grant", 64'(bus.grant_o), 64'(4'b0010));
    #2;
    rst = 1'b1;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    #1;
    check("arst_grant", 64'(bus.grant_o), 0);
    check("arst_s_cyc", 64'(bus.s_cyc_o), 0);
    #1;
    rst = 1'b0;
    step();
    check("arst_first_winner", 64'(bus.grant_o), 64'(4'b0001));
    clear_inputs();
    step();
    step();

    // Stalled slave: master 2 strobes and no response ever arrives.
    do_reset();
    bus.m_cyc_i[2] = 1'b1;
    bus.m_stb_i[2] = 1'b1;
    settle();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_err = (i == 9) ? 4'b0100 : 4'b0000;
      check("wd_err", 64'(bus.m_err_o), 64'(exp_err));
      check("wd_s_cyc", 64'(bus.s_cyc_o), (i == 9) ? 64'd0 : 64'd1);
    end
    step();
    check("wd_release", 64'(bus.grant_o), 0);
    check("wd_err_pulse_end", 64'(bus.m_err_o), 0);
`else
    for (int i = 1; i <= 12; i++) begin
      step();
      check("stall_grant_held", 64'(bus.grant_o), 64'(4'b0100));
      check("stall_no_err", 64'(bus.m_err_o), 0);
    end
`endif
    clear_inputs();
    step();
    step();
    check("final_idle", 64'(bus.grant_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
